ldst_seq: RTL and testbench

LDST_SEQ -- requirements
Module: ldst_seq

---
 rtl/ldst_seq_if.sv | 19 +
 rtl/ldst_seq.sv | 144 ++++++++++++++
 tb/tb_ldst_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_seq_if.sv
// Issue handshake between the upstream scheduler and the ld/st sequencer.
//   issue_valid   : an ld/st instruction is offered
//   issue_ready   : sequencer accepts an issue this cycle
//   issue_control : control word of the offered instruction (bit 15 ld, bit 16 st)
//   issue_mask    : active-thread mask of the offered instruction
interface ldst_seq_if #(
  parameter int SP_PER_MP     = 8,
  parameter int CONTROL_WIDTH = 17
);
  logic                     issue_valid;
  logic                     issue_ready;
  logic [CONTROL_WIDTH-1:0] issue_control;
  logic [SP_PER_MP-1:0]     issue_mask;

  modport master (output issue_valid, output issue_control, output issue_mask,
                  input  issue_ready);
  modport slave  (input  issue_valid, input  issue_control, input  issue_mask,
                  output issue_ready);
endinterface

// File: rtl/ldst_seq.sv
// Load/store bank-conflict sequencer. Broadcasts the pending thread mask to all
// L1 banks, retires the threads each bank serviced, and repeats passes until
// every thread is done, no progress is made, or the pass budget runs out.
//   clk, rst_n      : clock, async active-low reset
//   issue           : issue handshake (slave side)
//   abort           : cancel in-flight instruction
//   bank_next_mask  : per-bank mask of threads still pending after this pass
//   cur_mask        : mask broadcast to banks (0 when idle)
//   control_out     : control broadcast to banks (0 when idle)
//   stall           : busy, hold upstream
//   wb_valid/wb_mask: load data valid for threads served by the previous pass
//   done / err      : one-cycle completion / failure pulses
//   pass_count      : passes used by the current or last instruction
//
// state  | meaning
// IDLE   | waiting for an issue; banks see zero mask/control
// ACCESS | one bank pass per cycle over the pending mask
module ldst_seq #(
  parameter int SP_PER_MP     = 8,
  parameter int CONTROL_WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ldst_seq_if.slave                  issue,
  input  logic                       abort,
  input  logic [SP_PER_MP-1:0]       bank_next_mask [SP_PER_MP],
  output logic [SP_PER_MP-1:0]       cur_mask,
  output logic [CONTROL_WIDTH-1:0]   control_out,
  output logic                       stall,
  output logic                       wb_valid,
  output logic [SP_PER_MP-1:0]       wb_mask,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(SP_PER_MP):0] pass_count
);
  localparam int PCW = $clog2(SP_PER_MP) + 1;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  state_t state, state_nxt;

  logic [CONTROL_WIDTH-1:0] ctrl_q;
  logic [SP_PER_MP-1:0]     pending;
  logic [SP_PER_MP-1:0]     remaining;
  logic [SP_PER_MP-1:0]     served;
  logic                     ready;
  logic                     accept;
  logic                     is_ld, is_st;
  logic                     legal, both;
  logic                     last_pass;
  logic                     no_progress;

  assign is_ld  = issue.issue_control[15];
  assign is_st  = issue.issue_control[16];
  assign legal  = (is_ld ^ is_st) && (issue.issue_mask != '0);
  assign both   = is_ld && is_st;
  // abort wins over acceptance even though it otherwise does nothing in IDLE
  assign accept = issue.issue_valid && (state == IDLE) && !abort;
  assign issue.issue_ready = ready;

  always_comb begin
    remaining = '0;
    for (int b = 0; b < SP_PER_MP; b++) remaining = remaining | bank_next_mask[b];
    remaining = remaining & pending;
    served    = pending & ~remaining;
  end

  // the pass being executed now is the SP_PER_MP-th one
  assign last_pass   = (pass_count == PCW'(SP_PER_MP - 1));
  assign no_progress = (remaining == pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept && legal) state_nxt = ACCESS;
      ACCESS: if (abort || remaining == '0 || no_progress || last_pass) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready       = (state == IDLE);
    stall       = (state == ACCESS);
    cur_mask    = '0;
    control_out = '0;
    if (state == ACCESS) begin
      cur_mask    = pending;
      control_out = ctrl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      pending    <= '0;
      pass_count <= '0;
      wb_valid   <= 1'b0;
      wb_mask    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      wb_valid <= 1'b0;
      wb_mask  <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              ctrl_q     <= issue.issue_control;
              pending    <= issue.issue_mask;
              pass_count <= '0;
            end else if (both) begin
              err <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (abort) begin
            pending <= '0;
            ctrl_q  <= '0;
          end else begin
            pass_count <= pass_count + PCW'(1);
            pending    <= remaining;
            // BRAM read data appears one cycle after the pass
            if (ctrl_q[15]) begin
              wb_valid <= 1'b1;
              wb_mask  <= served;
            end
            if (remaining == '0)            done <= 1'b1;
            else if (no_progress || last_pass) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ldst_seq.sv
module tb_ldst_seq;
  localparam int SP = 8;
  localparam int CW = 17;
  localparam logic [CW-1:0] LD  = 17'h08000;
  localparam logic [CW-1:0] ST  = 17'h10000;
  localparam logic [CW-1:0] LDX = 17'h08123;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          abort = 0;
  logic [SP-1:0] bnm [SP];
  logic [SP-1:0] cur_mask;
  logic [CW-1:0] control_out;
  logic          stall, wb_valid, done, err;
  logic [SP-1:0] wb_mask;
  logic [3:0]    pass_count;

  int n_tests = 0;
  int n_fail  = 0;

  ldst_seq_if #(.SP_PER_MP(SP), .CONTROL_WIDTH(CW)) issue_bus ();

  ldst_seq #(.SP_PER_MP(SP), .CONTROL_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue_bus), .abort(abort),
    .bank_next_mask(bnm), .cur_mask(cur_mask), .control_out(control_out),
    .stall(stall), .wb_valid(wb_valid), .wb_mask(wb_mask), .done(done),
    .err(err), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_banks();
    for (int b = 0; b < SP; b++) bnm[b] = '0;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [SP-1:0] m);
    issue_bus.issue_valid   = v;
    issue_bus.issue_control = c;
    issue_bus.issue_mask    = m;
  endtask

  task automatic test_reset();
    drive(0, '0, '0);
    clr_banks();
    rst_n = 0;
    step();
    n_tests++; if (issue_bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", issue_bus.issue_ready); end
    n_tests++; if ({stall, wb_valid, done, err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {stall, wb_valid, done, err}); end
    n_tests++; if ({cur_mask, control_out, wb_mask, pass_count} !== '0) begin n_fail++; $display("FAIL reset_buses got %h want 0", {cur_mask, control_out, wb_mask, pass_count}); end
    rst_n = 1;
    step();
  endtask

  task automatic test_load_single();
    clr_banks();
    drive(1, LDX, 8'hFF);
    step();
    drive(0, '0, '0);
    n_tests++; if ({stall, issue_bus.issue_ready} !== 2'b10) begin n_fail++; $display("FAIL ld1_busy got %b want 10", {stall, issue_bus.issue_ready}); end
    n_tests++; if (cur_mask !== 8'hFF || control_out !== LDX) begin n_fail++; $display("FAIL ld1_bcast got %h/%h want ff/%h", cur_mask, control_out, LDX); end
    step();
    n_tests++; if ({wb_valid, done, err, stall} !== 4'b1100) begin n_fail++; $display("FAIL ld1_end got %b want 1100", {wb_valid, done, err, stall}); end
    n_tests++; if (wb_mask !== 8'hFF || pass_count !== 4'd1) begin n_fail++; $display("FAIL ld1_wb got %h/%0d want ff/1", wb_mask, pass_count); end
    n_tests++; if (cur_mask !== 8'h00 || control_out !== '0) begin n_fail++; $display("FAIL ld1_idle_bcast got %h/%h want 0/0", cur_mask, control_out); end
    step();
    n_tests++; if ({wb_valid, done} !== 2'b00 || pass_count !== 4'd1) begin n_fail++; $display("FAIL ld1_hold got %b/%0d want 00/1", {wb_valid, done}, pass_count); end
  endtask

  task automatic test_store_peel();
    logic [SP-1:0] pend;
    clr_banks();
    drive(1, ST, 8'hFF);
    step();
    drive(0, '0, '0);
    for (int k = 1; k <= 8; k++) begin
      pend = 8'hFF << (k - 1);
      n_tests++; if (cur_mask !== pend || stall !== 1'b1) begin n_fail++; $display("FAIL st_pass%0d_mask got %h/%b want %h/1", k, cur_mask, stall, pend); end
      bnm[0] = 8'hFF << k;
      step();
      n_tests++; if (wb_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL st_pass%0d_wb got %b/%b want 0/0", k, wb_valid, err); end
      n_tests++; if (done !== (k == 8)) begin n_fail++; $display("FAIL st_pass%0d_done got %b want %b", k, done, (k == 8)); end
    end
    n_tests++; if (pass_count !== 4'd8 || stall !== 1'b0) begin n_fail++; $display("FAIL st_count got %0d/%b want 8/0", pass_count, stall); end
    clr_banks();
  endtask

  task automatic test_load_two_pass();
    clr_banks();
    drive(1, LD, 8'h0F);
    step();
    drive(0, '0, '0);
    bnm[3] = 8'h08; bnm[5] = 8'h02; bnm[1] = 8'hF0;
    step();
    n_tests++; if ({wb_valid, done, stall} !== 3'b101 || wb_mask !== 8'h05) begin n_fail++; $display("FAIL ld2_p1 got %b/%h want 101/05", {wb_valid, done, stall}, wb_mask); end
    n_tests++; if (cur_mask !== 8'h0A) begin n_fail++; $display("FAIL ld2_pend got %h want 0a", cur_mask); end
    clr_banks();
    step();
    n_tests++; if ({wb_valid, done, stall} !== 3'b110 || wb_mask !== 8'h0A) begin n_fail++; $display("FAIL ld2_p2 got %b/%h want 110/0a", {wb_valid, done, stall}, wb_mask); end
    n_tests++; if (pass_count !== 4'd2) begin n_fail++; $display("FAIL ld2_count got %0d want 2", pass_count); end
  endtask

  task automatic test_no_progress();
    clr_banks();
    drive(1, ST, 8'h03);
    step();
    drive(0, '0, '0);
    bnm[2] = 8'h03;
    step();
    n_tests++; if ({err, done, stall, wb_valid} !== 4'b1000) begin n_fail++; $display("FAIL np_err got %b want 1000", {err, done, stall, wb_valid}); end
    n_tests++; if (cur_mask !== 8'h00 || issue_bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL np_idle got %h/%b want 00/1", cur_mask, issue_bus.issue_ready); end
    clr_banks();
    step();
    n_tests++; if ({err, done} !== 2'b00) begin n_fail++; $display("FAIL np_once got %b want 00", {err, done}); end
  endtask

  task automatic test_illegal_and_nop();
    clr_banks();
    drive(1, LD | ST, 8'hFF);
    step();
    drive(0, '0, '0);
    n_tests++; if ({err, done, stall} !== 3'b100 || cur_mask !== 8'h00) begin n_fail++; $display("FAIL both_err got %b/%h want 100/00", {err, done, stall}, cur_mask); end
    step();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL both_once got %b want 0", err); end
    drive(1, LD, 8'h00);
    step();
    drive(0, '0, '0);
    n_tests++; if ({done, err, stall, wb_valid} !== 4'b1000 || cur_mask !== 8'h00) begin n_fail++; $display("FAIL nop_done got %b/%h want 1000/00", {done, err, stall, wb_valid}, cur_mask); end
    drive(1, 17'h00055, 8'hFF);
    step();
    drive(0, '0, '0);
    n_tests++; if ({done, err, stall} !== 3'b100) begin n_fail++; $display("FAIL noldst_done got %b want 100", {done, err, stall}); end
    step();
  endtask

  task automatic test_abort();
    clr_banks();
    abort = 1;
    drive(1, LD, 8'hFF);
    step();
    drive(0, '0, '0);
    abort = 0;
    n_tests++; if ({stall, done, err} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got %b want 000", {stall, done, err}); end
    drive(1, LD, 8'h07);
    step();
    drive(0, '0, '0);
    bnm[0] = 8'h06;
    step();
    n_tests++; if ({wb_valid, stall} !== 2'b11 || wb_mask !== 8'h01) begin n_fail++; $display("FAIL abort_p1 got %b/%h want 11/01", {wb_valid, stall}, wb_mask); end
    bnm[0] = 8'h04;
    abort = 1;
    step();
    abort = 0;
    n_tests++; if ({stall, wb_valid, done, err} !== 4'b0000) begin n_fail++; $display("FAIL abort_flags got %b want 0000", {stall, wb_valid, done, err}); end
    n_tests++; if ({cur_mask, control_out, wb_mask} !== '0) begin n_fail++; $display("FAIL abort_buses got %h want 0", {cur_mask, control_out, wb_mask}); end
    clr_banks();
    step();
    n_tests++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL abort_after got %b want 00", {done, err}); end
    drive(1, LD, 8'hFF);
    step();
    drive(0, '0, '0);
    n_tests++; if (stall !== 1'b1 || cur_mask !== 8'hFF) begin n_fail++; $display("FAIL abort_reissue got %b/%h want 1/ff", stall, cur_mask); end
    step();
    n_tests++; if ({done, wb_valid} !== 2'b11) begin n_fail++; $display("FAIL abort_reissue_done got %b want 11", {done, wb_valid}); end
  endtask

  task automatic test_reset_mid();
    clr_banks();
    drive(1, ST, 8'hFF);
    step();
    drive(0, '0, '0);
    bnm[0] = 8'hFE;
    step();
    n_tests++; if (stall !== 1'b1 || cur_mask !== 8'hFE) begin n_fail++; $display("FAIL rmid_busy got %b/%h want 1/fe", stall, cur_mask); end
    #2 rst_n = 0;
    #1;
    n_tests++; if ({stall, wb_valid, done, err, issue_bus.issue_ready} !== 5'b00001) begin n_fail++; $display("FAIL rmid_flags got %b want 00001", {stall, wb_valid, done, err, issue_bus.issue_ready}); end
    n_tests++; if ({cur_mask, control_out, wb_mask, pass_count} !== '0) begin n_fail++; $display("FAIL rmid_buses got %h want 0", {cur_mask, control_out, wb_mask, pass_count}); end
    step();
    rst_n = 1;
    clr_banks();
    step();
    step();
    n_tests++; if ({done, err, stall} !== 3'b000) begin n_fail++; $display("FAIL rmid_after got %b want 000", {done, err, stall}); end
    drive(1, ST, 8'h0F);
    step();
    drive(0, '0, '0);
    n_tests++; if (stall !== 1'b1 || control_out !== ST) begin n_fail++; $display("FAIL rmid_reissue got %b/%h want 1/%h", stall, control_out, ST); end
    step();
    n_tests++; if ({done, wb_valid} !== 2'b10) begin n_fail++; $display("FAIL rmid_done got %b want 10", {done, wb_valid}); end
  endtask

  task automatic test_back_to_back();
    clr_banks();
    drive(1, LD, 8'hFF);
    step();
    drive(1, ST, 8'h0F);
    n_tests++; if (cur_mask !== 8'hFF) begin n_fail++; $display("FAIL b2b_first got %h want ff", cur_mask); end
    step();
    n_tests++; if ({done, issue_bus.issue_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_done_ready got %b want 11", {done, issue_bus.issue_ready}); end
    step();
    drive(0, '0, '0);
    n_tests++; if (stall !== 1'b1 || cur_mask !== 8'h0F || control_out !== ST) begin n_fail++; $display("FAIL b2b_second got %b/%h/%h want 1/0f/%h", stall, cur_mask, control_out, ST); end
    step();
    n_tests++; if ({done, wb_valid, stall} !== 3'b100 || pass_count !== 4'd1) begin n_fail++; $display("FAIL b2b_end got %b/%0d want 100/1", {done, wb_valid, stall}, pass_count); end
  endtask

  initial begin
    test_reset();
    test_load_single();
    test_store_peel();
    test_load_two_pass();
    test_no_progress();
    test_illegal_and_nop();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
